// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared CPU constants: ALU opcodes, access sizes, LSU state encoding
package lsu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_ILL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Misaligned half/word or the reserved size encoding never reaches memory.
  function automatic logic is_fault(input size_e size, input logic [1:0] lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lo[0];
      SIZE_W:  return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - pipeline request, memory bus and response signals of the LSU
interface lsu_if #(parameter int BW = 32);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [BW-1:0] req_addr;
  logic [BW-1:0] req_wdata;
  logic [4:0]    req_rd;
  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [BW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [BW-1:0] mem_rdata;
  logic          resp_valid;
  logic          resp_we;
  logic [4:0]    resp_rd;
  logic [BW-1:0] resp_data;
  logic          resp_err;
  logic          busy;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output resp_valid, resp_we, resp_rd, resp_data, resp_err, busy
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  resp_valid, resp_we, resp_rd, resp_data, resp_err, busy
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store byte-enable/lane replication and load lane extract/extension
module lsu_align
  import lsu_pkg::*;
#(
  parameter int BW = 32
) (
  input  size_e         size,
  input  logic          is_unsigned,
  input  logic [1:0]    lane,
  input  logic [BW-1:0] wdata,
  input  logic [BW-1:0] rdata,
  output logic [3:0]    be,
  output logic [BW-1:0] wdata_lane,
  output logic [BW-1:0] rdata_ext
);
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be         = 4'b0000;
    wdata_lane = '0;
    rdata_ext  = '0;
    rbyte      = rdata[{lane, 3'b000} +: 8];
    rhalf      = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_B: begin
        be         = 4'b0001 << lane;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = is_unsigned ? {{(BW-8){1'b0}}, rbyte} : {{(BW-8){rbyte[7]}}, rbyte};
      end
      SIZE_H: begin
        be         = 4'b0011 << lane;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = is_unsigned ? {{(BW-16){1'b0}}, rhalf} : {{(BW-16){rhalf[15]}}, rhalf};
      end
      SIZE_W: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit between the pipeline and a gnt/rvalid memory port
module lsu
  import lsu_pkg::*;
#(
  parameter int BW = 32
) (
  input logic   clk,
  input logic   rst,
  lsu_if.slave  bus
);
  lsu_state_e    state_q, state_d;
  logic          we_q, we_d, uns_q, uns_d;
  size_e         size_q, size_d;
  logic [1:0]    lane_q, lane_d;
  logic [4:0]    rd_q, rd_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [BW-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          resp_valid_q, resp_valid_d, resp_we_q, resp_we_d, resp_err_q, resp_err_d;
  logic [4:0]    resp_rd_q, resp_rd_d;
  logic [BW-1:0] resp_data_q, resp_data_d;

  logic          idle;
  size_e         al_size;
  logic          al_uns;
  logic [1:0]    al_lane;
  logic [3:0]    al_be;
  logic [BW-1:0] al_wdata, al_rdata;

  // In IDLE the aligner sees the live request; afterwards it sees the captured op.
  assign idle    = (state_q == ST_IDLE);
  assign al_size = idle ? size_e'(bus.req_size) : size_q;
  assign al_uns  = idle ? bus.req_unsigned : uns_q;
  assign al_lane = idle ? bus.req_addr[1:0] : lane_q;

  lsu_align #(.BW(BW)) u_align (
    .size        (al_size),
    .is_unsigned (al_uns),
    .lane        (al_lane),
    .wdata       (bus.req_wdata),
    .rdata       (bus.mem_rdata),
    .be          (al_be),
    .wdata_lane  (al_wdata),
    .rdata_ext   (al_rdata)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    uns_d        = uns_q;
    size_d       = size_q;
    lane_d       = lane_q;
    rd_d         = rd_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_we_d    = 1'b0;
    resp_err_d   = 1'b0;
    resp_rd_d    = '0;
    resp_data_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d   = bus.req_we;
          uns_d  = bus.req_unsigned;
          size_d = size_e'(bus.req_size);
          lane_d = bus.req_addr[1:0];
          rd_d   = bus.req_rd;
          if (is_fault(size_e'(bus.req_size), bus.req_addr[1:0])) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = ST_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_we;
            mem_addr_d  = {bus.req_addr[BW-1:2], 2'b00};
            mem_be_d    = al_be;
            mem_wdata_d = bus.req_we ? al_wdata : '0;
          end
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = 4'b0000;
          mem_wdata_d = '0;
          if (we_q) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rd_d    = rd_q;
          resp_we_d    = (rd_q != 5'd0);
          resp_data_d  = al_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= SIZE_B;
      lane_q       <= 2'b00;
      rd_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      uns_q        <= uns_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      rd_q         <= rd_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_we_q    <= resp_we_d;
      resp_err_q   <= resp_err_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign bus.req_ready  = idle;
  assign bus.busy       = !idle;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_we    = resp_we_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rd    = resp_rd_q;
  assign bus.resp_data  = resp_data_q;
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed LSU bench with an expected-response queue checked by a monitor
module tb_lsu;
  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic        chk_rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_push = 0;
  int   n_resp = 0;
  exp_t exp_q[$];

  lsu_if #(.BW(32)) bus ();

  lsu #(.BW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares every response pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.resp_valid) begin
        n_resp++;
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
          chk("resp_we", {31'd0, bus.resp_we}, {31'd0, e.we});
          chk("resp_data", bus.resp_data, e.data);
          if (e.chk_rd) chk("resp_rd", {27'd0, bus.resp_rd}, {27'd0, e.rd});
        end
      end else begin
        chk("resp_idle_zero", {bus.resp_data[31:1], bus.resp_data[0] | bus.resp_we | bus.resp_err},
            32'd0);
      end
    end
  end

  task automatic do_op(input string name, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                       input exp_t e);
    @(negedge clk);
    chk({name, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_rd       = rd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    exp_q.push_back(e);
    n_push++;
    if (e.err) begin
      chk({name, "_no_memreq"}, {31'd0, bus.mem_req}, 32'd0);
    end else begin
      for (int i = 0; i <= gnt_dly; i++) begin
        chk({name, "_mem_req"}, {31'd0, bus.mem_req}, 32'd1);
        chk({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
        chk({name, "_mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        chk({name, "_mem_be"}, {28'd0, bus.mem_be}, {28'd0, exp_be});
        chk({name, "_mem_we"}, {31'd0, bus.mem_we}, {31'd0, we});
        if (we) chk({name, "_mem_wdata"}, bus.mem_wdata, exp_wdata);
        if (i == gnt_dly) bus.mem_gnt = 1'b1;
        @(negedge clk);
      end
      bus.mem_gnt = 1'b0;
      if (!we) begin
        for (int i = 0; i < rv_dly; i++) begin
          chk({name, "_wait_busy"}, {31'd0, bus.busy}, 32'd1);
          chk({name, "_wait_noresp"}, {31'd0, bus.resp_valid}, 32'd0);
          @(negedge clk);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
      end
    end
    chk({name, "_resp_latency"}, {31'd0, bus.resp_valid}, 32'd1);
    @(negedge clk);
    chk({name, "_single_pulse"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({name, "_back_idle"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  function automatic exp_t mk(input logic we, input logic [4:0] rd, input logic [31:0] data,
                              input logic err, input logic chk_rd);
    exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.err = err; e.chk_rd = chk_rd;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_rd = 5'd0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);

    do_op("sw",  1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0,
          4'b1111, 32'hDEADBEEF, mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
    do_op("lb",  1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd5, 0, 0, 32'h80FF_0000,
          4'b1000, 32'h0, mk(1'b1, 5'd5, 32'hFFFFFF80, 1'b0, 1'b1));
    do_op("lbu", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd5, 0, 0, 32'h80FF_0000,
          4'b1000, 32'h0, mk(1'b1, 5'd5, 32'h00000080, 1'b0, 1'b1));
    do_op("lh",  1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 5'd9, 0, 0, 32'h8001_1234,
          4'b1100, 32'h0, mk(1'b1, 5'd9, 32'hFFFF8001, 1'b0, 1'b1));
    do_op("sh",  1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 5'd0, 0, 0, 32'h0,
          4'b1100, 32'hABCDABCD, mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
    do_op("sb",  1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5, 5'd0, 1, 0, 32'h0,
          4'b0010, 32'hA5A5A5A5, mk(1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
    do_op("lw_mis", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd4, 0, 0, 32'h0,
          4'b0000, 32'h0, mk(1'b0, 5'd0, 32'h0, 1'b1, 1'b0));
    do_op("lh_mis", 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 5'd4, 0, 0, 32'h0,
          4'b0000, 32'h0, mk(1'b0, 5'd0, 32'h0, 1'b1, 1'b0));
    do_op("size11", 1'b1, 2'b11, 1'b0, 32'h100, 32'h1234, 5'd0, 0, 0, 32'h0,
          4'b0000, 32'h0, mk(1'b0, 5'd0, 32'h0, 1'b1, 1'b0));
    do_op("lw_slow", 1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 5'd7, 3, 2, 32'h12345678,
          4'b1111, 32'h0, mk(1'b1, 5'd7, 32'h12345678, 1'b0, 1'b1));
    do_op("lhu_x0", 1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 5'd0, 0, 0, 32'h0000F00D,
          4'b0011, 32'h0, mk(1'b0, 5'd0, 32'h0000F00D, 1'b0, 1'b1));
    do_op("lbu_l1", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 5'd3, 0, 1, 32'h0000C300,
          4'b0010, 32'h0, mk(1'b1, 5'd3, 32'h000000C3, 1'b0, 1'b1));

    // Reset while a load waits for data: the late rvalid must be dropped.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h300; bus.req_rd = 5'd6;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rstw_mem_req", {31'd0, bus.mem_req}, 32'd1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    chk("rstw_in_wait", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rstw_mem_req_low", {31'd0, bus.mem_req}, 32'd0);
    chk("rstw_resp_low", {31'd0, bus.resp_valid}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_gnt    = 1'b1;
    bus.mem_rdata  = 32'hCAFEF00D;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt    = 1'b0;
    chk("rstw_late_rvalid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rstw_still_idle", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clk);
    chk("rstw_no_resp", {31'd0, bus.resp_valid}, 32'd0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("resp_count", n_resp, n_push);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
